// File: rtl/mem_ctrl_if.sv
// Request/response handshake and memory strobe/address signals for mem_ctrl.
// The bidirectional data pin stays a direct port on the controller.
interface mem_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_read, mem_write, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-request memory controller driving an asynchronous SRAM-style bus with
// one setup and one hold cycle around a single-cycle write strobe.
module mem_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         bus,
    inout  wire  [DWIDTH-1:0] mem_data
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_SETUP  = 3'd1;
    localparam logic [2:0] WR_PULSE  = 3'd2;
    localparam logic [2:0] WR_HOLD   = 3'd3;
    localparam logic [2:0] RD_ASSERT = 3'd4;
    localparam logic [2:0] RD_SAMPLE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic              accept_s;
    logic [AWIDTH-1:0] mem_addr_r;
    logic [DWIDTH-1:0] wdata_r;
    logic [DWIDTH-1:0] rdata_r;
    logic              req_ready_r;
    logic              busy_r;
    logic              rsp_valid_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              data_oe_r;

    assign accept_s = (state_r == IDLE) && bus.req_valid;

    // Next-state sequencing; the state itself records read versus write.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next_s = bus.req_we ? WR_SETUP : RD_ASSERT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR_SETUP:  state_next_s = WR_PULSE;
            WR_PULSE:  state_next_s = WR_HOLD;
            WR_HOLD:   state_next_s = DONE;
            RD_ASSERT: state_next_s = RD_SAMPLE;
            RD_SAMPLE: state_next_s = DONE;
            DONE:      state_next_s = IDLE;
            default:   state_next_s = IDLE;
        endcase
    end

    // State, request capture and outputs decoded from the next state so every
    // bus-facing signal comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_addr_r  <= {AWIDTH{1'b0}};
            wdata_r     <= {DWIDTH{1'b0}};
            rdata_r     <= {DWIDTH{1'b0}};
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            data_oe_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == IDLE);
            busy_r      <= (state_next_s != IDLE);
            rsp_valid_r <= (state_next_s == DONE);
            mem_read_r  <= (state_next_s == RD_ASSERT) || (state_next_s == RD_SAMPLE);
            mem_write_r <= (state_next_s == WR_PULSE);
            data_oe_r   <= (state_next_s == WR_SETUP) || (state_next_s == WR_PULSE) ||
                           (state_next_s == WR_HOLD);
            if (accept_s) begin
                mem_addr_r <= bus.req_addr;
                wdata_r    <= bus.req_wdata;
            end
            if (state_r == RD_SAMPLE) begin
                rdata_r <= mem_data;
            end
        end
    end

    assign mem_data      = data_oe_r ? wdata_r : {DWIDTH{1'bz}};
    assign bus.req_ready = req_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_read  = mem_read_r;
    assign bus.mem_write = mem_write_r;
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data width of request and memory bus.
REQ-002 SHALL have parameter AWIDTH, default 5, address width of request and memory bus.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  client request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  AWIDTH  request address.
REQ-009 SHALL have port req_wdata  input  DWIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse for read or write.
REQ-011 SHALL have port rsp_rdata  output  DWIDTH  read data, valid with rsp_valid after a read.
REQ-012 SHALL have port mem_addr  output  AWIDTH  address to memory.
REQ-013 SHALL have port mem_data  inout  DWIDTH  bidirectional memory data bus.
REQ-014 SHALL have port mem_read  output  1  memory read strobe.
REQ-015 SHALL have port mem_write  output  1  memory write strobe; memory captures on its rising edge.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ASSERT, RD_SAMPLE, DONE.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-019 SHALL, on acceptance, register req_addr, req_we and req_wdata; request inputs are ignored outside acceptance.
REQ-020 SHALL sequence a write as IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> DONE -> IDLE, one cycle per state.
REQ-021 SHALL sequence a read as IDLE -> RD_ASSERT -> RD_SAMPLE -> DONE -> IDLE, one cycle per state.
REQ-022 SHALL drive mem_addr from the registered address in every non-IDLE state, stable for the whole transaction.
REQ-023 SHALL drive mem_data with the registered write data in WR_SETUP, WR_PULSE and WR_HOLD, and high-Z in all other states.
REQ-024 SHALL assert mem_write only in WR_PULSE, giving one setup and one hold cycle of address and data around its rising edge.
REQ-025 SHALL assert mem_read in RD_ASSERT and RD_SAMPLE only.
REQ-026 SHALL never assert mem_read and mem_write together, and never drive mem_data while mem_read is high.
REQ-027 SHALL capture mem_data into rsp_rdata on the rising edge that ends RD_SAMPLE.
REQ-028 SHALL hold rsp_rdata unchanged across writes and until the next read capture.
REQ-029 SHALL assert rsp_valid only in DONE, for exactly one cycle; there is no response backpressure.
REQ-030 SHALL give latency from the accept edge to rsp_valid high of 4 cycles for a write and 3 cycles for a read.
REQ-031 SHALL keep req_ready low in DONE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-032 SHALL produce registered (glitch-free) mem_read, mem_write and mem_addr outputs.

Reset
REQ-033 SHALL, while rst is high, force IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_read=0, mem_write=0, mem_data high-Z.
REQ-034 SHALL, on reset asserted mid-transaction, abort immediately without completing or reporting the transaction.
REQ-035 SHALL make no guarantee about memory contents when reset falls during WR_PULSE; the strobe drop itself produces no rising edge.
REQ-036 SHALL accept a new request on the first rising edge after rst deasserts.

Verification
REQ-037 Write: req addr=5'h03, wdata=8'hA5, we=1.
 -> mem_write high exactly one cycle, with mem_addr=3 and mem_data=A5 one cycle before and one cycle after.
 -> rsp_valid at accept+4.
REQ-038 Read-back: read addr=5'h03 after REQ-037 -> mem_read high 2 cycles, rsp_rdata=8'hA5 with rsp_valid at accept+3.
REQ-039 Back-to-back: req_valid held high for write addr 0 = 8'h11 then read addr 0.
 -> second accept no earlier than one IDLE cycle after DONE.
 -> read returns 8'h11.
REQ-040 Boundary: write 8'hFF to addr 5'h1F and 8'h00 to addr 5'h00, then read both -> 8'hFF and 8'h00; no aliasing.
REQ-041 Reset mid-op: assert rst during RD_ASSERT.
 -> mem_read=0 and busy=0 immediately; no rsp_valid; mem_data high-Z.
 -> next write accepted on the first edge after release.
REQ-042 Bus checker on every cycle of all tests:
 -> mem_read & mem_write never both 1.
 -> mem_data driven by mem_ctrl only outside mem_read.
 -> mem_addr stable while busy.
